// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/subtract opcode encoding, status flag bit order and
// small helpers that decode an opcode into B inversion and stage-0 carry-in.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;  // a + b
    localparam logic [1:0] OP_SUB = 2'b01;  // a + ~b + 1
    localparam logic [1:0] OP_ADC = 2'b10;  // a + b + cin
    localparam logic [1:0] OP_SBC = 2'b11;  // a + ~b + cin

    // Bit positions inside a packed status-flag vector.
    localparam int unsigned FLAG_COUT = 0;
    localparam int unsigned FLAG_OVF  = 1;
    localparam int unsigned FLAG_ZERO = 2;
    localparam int unsigned FLAG_NEG  = 3;
    localparam int unsigned NUM_FLAGS = 4;

    // SUB and SBC both work on the one's complement of B.
    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain slice of the pipelined adder.
// Ports:
//   a_i, b_i  SW-bit slice operands (b_i already inverted for subtract ops)
//   cin_i     carry into the slice
//   sum_o     SW-bit slice sum
//   cout_o    carry out of the slice MSB
//   cmsb_o    carry into the slice MSB (used for signed overflow in the top slice)
module addsub_slice #(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o,
    output logic          cmsb_o
);

    logic [SW:0] full;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};
        sum_o  = full[SW-1:0];
        cout_o = full[SW];
        // The sum bit is a ^ b ^ carry-in, so the carry into the MSB can be recovered from it.
        cmsb_o = a_i[SW-1] ^ b_i[SW-1] ^ full[SW-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two-operand add/subtract unit with valid/ready handshake.
// The WIDTH-bit carry chain is split into STAGES registered slices of SW = WIDTH/STAGES bits.
// Each beat carries its not-yet-added upper operand slices forward and its finished lower
// result slices along with it, so the full result leaves the last stage aligned.
// Optional build macro ADDSUB_SAT_EN: signed saturation of the result on overflow.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; in_ready = !out_valid | out_ready
//   in_op, in_a, in_b, in_cin  opcode (ADD/SUB/ADC/SBC), operands, carry-in
//   out_valid/out_ready      output handshake
//   out_result               WIDTH-bit sum/difference (modulo 2^WIDTH)
//   out_cout, out_ovf        carry out of MSB (1 = no borrow on subtract), signed overflow
//   out_zero, out_neg        result is zero, result MSB
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;
    // Intermediate stage registers; the last stage is the output register itself.
    localparam int unsigned NMID = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] b_in;
    logic             cin0;

    // Intermediate stage state.
    logic [NMID-1:0]  valid_d, valid_q;
    logic [NMID-1:0]  carry_d, carry_q;
    logic [WIDTH-1:0] res_d [NMID];
    logic [WIDTH-1:0] res_q [NMID];
    logic [WIDTH-1:0] b_d   [NMID];
    logic [WIDTH-1:0] b_q   [NMID];

    // Output stage state.
    logic                 out_valid_d, out_valid_q;
    logic [WIDTH-1:0]     out_result_d, out_result_q;
    logic [NUM_FLAGS-1:0] flags_d, flags_q;

    // What each stage sees as its input beat.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_res [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];

    logic [SW-1:0]     slice_sum [STAGES];
    logic [STAGES-1:0] slice_cout;
    logic [STAGES-1:0] slice_cmsb;

    logic [WIDTH-1:0] raw_res;
    logic [WIDTH-1:0] final_res;
    logic             raw_cout;
    logic             raw_ovf;

    assign advance = !out_valid_q || out_ready;
    assign accept  = in_valid && advance;
    assign in_ready = advance;

    assign b_in = op_inverts_b(in_op) ? ~in_b : in_b;
    assign cin0 = op_carry_in(in_op, in_cin);

    // res vectors hold A in not-yet-added slices and the sum in completed slices.
    always_comb begin
        src_v[0]   = accept;
        src_c[0]   = cin0;
        src_res[0] = in_a;
        src_b[0]   = b_in;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_v[k]   = valid_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_res[k] = res_q[k-1];
            src_b[k]   = b_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(
            .SW(SW)
        ) u_slice (
            .a_i   (src_res[k][k*SW +: SW]),
            .b_i   (src_b[k][k*SW +: SW]),
            .cin_i (src_c[k]),
            .sum_o (slice_sum[k]),
            .cout_o(slice_cout[k]),
            .cmsb_o(slice_cmsb[k])
        );
    end

    always_comb begin
        raw_res                  = src_res[LAST];
        raw_res[LAST*SW +: SW]   = slice_sum[LAST];
        raw_cout                 = slice_cout[LAST];
        raw_ovf                  = slice_cmsb[LAST] ^ slice_cout[LAST];
`ifdef ADDSUB_SAT_EN
        // Raw MSB set on overflow means positive overflow, so clamp to max; else clamp to min.
        final_res = raw_ovf ? {~raw_res[WIDTH-1], {(WIDTH-1){raw_res[WIDTH-1]}}} : raw_res;
`else
        final_res = raw_res;
`endif
    end

    always_comb begin
        valid_d      = valid_q;
        carry_d      = carry_q;
        res_d        = res_q;
        b_d          = b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        flags_d      = flags_q;
        if (advance) begin
            for (int k = 0; k < int'(STAGES) - 1; k++) begin
                valid_d[k]             = src_v[k];
                carry_d[k]             = slice_cout[k];
                res_d[k]               = src_res[k];
                res_d[k][k*SW +: SW]   = slice_sum[k];
                b_d[k]                 = src_b[k];
            end
            out_valid_d = src_v[LAST];
            // Output data only changes with a real beat, so it stays put across bubbles.
            if (src_v[LAST]) begin
                out_result_d       = final_res;
                flags_d[FLAG_COUT] = raw_cout;
                flags_d[FLAG_OVF]  = raw_ovf;
                flags_d[FLAG_ZERO] = (final_res == '0);
                flags_d[FLAG_NEG]  = final_res[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            carry_q      <= '0;
            res_q        <= '{default: '0};
            b_q          <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            flags_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            carry_q      <= carry_d;
            res_q        <= res_d;
            b_q          <= b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_cout   = flags_q[FLAG_COUT];
    assign out_ovf    = flags_q[FLAG_OVF];
    assign out_zero   = flags_q[FLAG_ZERO];
    assign out_neg    = flags_q[FLAG_NEG];

endmodule
